gray_to_binary_stream: RTL and testbench

GRAY_TO_BINARY_STREAM -- requirements
Module: gray_to_binary_stream

---
 rtl/gray_to_binary_stream.sv | 124 ++++++++++++
 tb/tb_gray_to_binary_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_stream.sv
// Gray-to-binary decoder with a 2-entry skid buffer on the output and a registered ready.
// Define GRAY_SEQ_CHECK_EN to build in the Hamming-distance-1 sequence checker on accepted words.
module gray_to_binary_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gry_valid,
    input  logic [WIDTH-1:0] gry,
    output logic             gry_ready,
    output logic             bin_valid,
    output logic [WIDTH-1:0] bin,
    input  logic             bin_ready,
    output logic [15:0]      word_cnt,
    input  logic             err_clr,
    output logic             seq_err,
    output logic [7:0]       err_cnt
);

    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] data_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             gry_ready_q, gry_ready_d;
    logic [15:0]      word_cnt_q;
    logic             accept;
    logic             xfer;

    assign accept = gry_valid && gry_ready_q;
    assign xfer   = (count_q != 2'd0) && bin_ready;

    // Ready is computed from the next occupancy so it can be a flop with no path from bin_ready.
    always_comb begin
        count_d = count_q;
        if (accept && !xfer) begin
            count_d = count_q + 2'd1;
        end else if (!accept && xfer) begin
            count_d = count_q - 2'd1;
        end
        gry_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            gry_ready_q <= 1'b0;
            word_cnt_q  <= 16'd0;
        end else begin
            count_q     <= count_d;
            gry_ready_q <= gry_ready_d;
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (xfer) begin
                rd_ptr_q   <= ~rd_ptr_q;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: payload storage has no reset; bin is gated by bin_valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (accept) data_q[wr_ptr_q] <= gray_decode(gry);
    end

    assign gry_ready = gry_ready_q;
    assign bin_valid = (count_q != 2'd0);
    assign bin       = bin_valid ? data_q[rd_ptr_q] : '0;
    assign word_cnt  = word_cnt_q;

`ifdef GRAY_SEQ_CHECK_EN
    logic [WIDTH-1:0] hist_q;
    logic             hist_valid_q;
    logic             seq_err_q;
    logic [7:0]       err_cnt_q;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             violation;

    // Exactly one differing bit: non-zero and a power of two.
    assign diff      = gry ^ hist_q;
    assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign violation = accept && hist_valid_q && !one_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            if (accept) begin
                hist_q       <= gry;
                hist_valid_q <= 1'b1;
            end
            if (err_clr) begin
                seq_err_q <= violation;
                err_cnt_q <= violation ? 8'd1 : 8'd0;
            end else if (violation) begin
                seq_err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign seq_err = seq_err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign seq_err        = 1'b0;
    assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_gray_to_binary_stream.sv
// Randomized self-checking bench for gray_to_binary_stream (WIDTH=4) against a queue-based model.
// Checker expectations follow GRAY_SEQ_CHECK_EN; without it seq_err/err_cnt must stay 0.
module tb_gray_to_binary_stream;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         gry_valid;
    logic [W-1:0] gry;
    logic         gry_ready;
    logic         bin_valid;
    logic [W-1:0] bin;
    logic         bin_ready;
    logic [15:0]  word_cnt;
    logic         err_clr;
    logic         seq_err;
    logic [7:0]   err_cnt;

    gray_to_binary_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gry_valid(gry_valid),
        .gry      (gry),
        .gry_ready(gry_ready),
        .bin_valid(bin_valid),
        .bin      (bin),
        .bin_ready(bin_ready),
        .word_cnt (word_cnt),
        .err_clr  (err_clr),
        .seq_err  (seq_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: gray code of n is n ^ (n >> 1); invert that through a table.
    int unsigned inv_tab [16];
    int unsigned exp_q [$];
    int unsigned m_words;
    int unsigned m_pushed;
    int unsigned m_prev;
    bit          m_hist;
    bit          m_err;
    int unsigned m_errcnt;

    task automatic check_checker(input string tag);
`ifdef GRAY_SEQ_CHECK_EN
        check({tag, "_seq_err"}, seq_err, m_err);
        check({tag, "_err_cnt"}, err_cnt, m_errcnt);
`else
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    // Called at a negedge: check outputs against the model, drive inputs, advance the model
    // by the handshakes that the coming posedge will perform.
    task automatic cycle(input bit v, input int unsigned g, input bit r, input bit clr);
        bit viol;
        bit model_ready;
        check("bin_valid", bin_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("bin", bin, exp_q[0]);
        else                   check("bin_idle", bin, 0);
        check("gry_ready", gry_ready, exp_q.size() < 2);
        check("word_cnt", word_cnt, m_words);
        check_checker("cyc");

        gry_valid = v;
        gry       = g[W-1:0];
        bin_ready = r;
        err_clr   = clr;

        model_ready = exp_q.size() < 2;
        if (r && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            m_words = (m_words + 1) % 65536;
        end
        viol = 1'b0;
        if (v && model_ready) begin
            if (m_hist && $countones(g ^ m_prev) != 1) viol = 1'b1;
            m_hist = 1'b1;
            m_prev = g;
            exp_q.push_back(inv_tab[g]);
            m_pushed++;
        end
        if (clr) begin
            m_err    = viol;
            m_errcnt = viol ? 1 : 0;
        end else if (viol) begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
        end
        @(negedge clk);
    endtask

    // Entered at a negedge; asserts reset mid-cycle, checks the immediate effect, releases.
    task automatic do_reset();
        gry_valid = 1'b0;
        bin_ready = 1'b0;
        err_clr   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_bin_valid", bin_valid, 0);
        check("rst_bin", bin, 0);
        check("rst_gry_ready", gry_ready, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        exp_q.delete();
        m_words  = 0;
        m_hist   = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
        repeat (2) @(negedge clk);
        check("rst_hold_ready", gry_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        for (int n = 0; n < 16; n++) inv_tab[n ^ (n >> 1)] = n;
        m_pushed  = 0;
        rst_n     = 1'b0;
        gry_valid = 1'b0;
        gry       = '0;
        bin_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        do_reset();

        // Full gray sequence with downstream always ready.
        for (int n = 0; n < 16; n++) cycle(1'b1, n ^ (n >> 1), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);
        check("stream_word_cnt", word_cnt, 16);

        // Downstream stalled with continuous input: two words held, then drained.
        repeat (6) cycle(1'b1, $urandom_range(0, 15), 1'b0, 1'b0);
        check("stall_gry_ready", gry_ready, 0);
        check("stall_bin_valid", bin_valid, 1);
        repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
        check("stall_word_cnt", word_cnt, 18);

        // Random valid/ready over 1000 words.
        m_pushed = 0;
        cyc      = 0;
        while (m_pushed < 1000 && cyc < 20000) begin
            cycle(($urandom % 4) != 0, $urandom % 16, ($urandom % 3) != 0, 1'b0);
            cyc++;
        end
        check("rand_budget", m_pushed, 1000);
        repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
        check("rand_word_cnt", word_cnt, 1018);

        // Sequence checker: 0000,0001,0011,0000 -> one violation on the last word.
        do_reset();
        cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b1, 4'b0001, 1'b1, 1'b0);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
`ifdef GRAY_SEQ_CHECK_EN
        check("seq4_seq_err", seq_err, 1);
        check("seq4_err_cnt", err_cnt, 1);
`else
        check("seq4_seq_err_off", seq_err, 0);
        check("seq4_err_cnt_off", err_cnt, 0);
`endif
        cycle(1'b0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("clr_seq_err", seq_err, 0);
        check("clr_err_cnt", err_cnt, 0);

        // Clear coinciding with a fresh violation (repeated word).
        cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
`ifdef GRAY_SEQ_CHECK_EN
        check("clrviol_seq_err", seq_err, 1);
        check("clrviol_err_cnt", err_cnt, 1);
`else
        check("clrviol_seq_err_off", seq_err, 0);
        check("clrviol_err_cnt_off", err_cnt, 0);
`endif

        // Wrap-around step 1000 -> 0000 is legal.
        do_reset();
        cycle(1'b1, 4'b1000, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("wrap_seq_err", seq_err, 0);

        // 300 repeats saturate the error count.
        repeat (300) cycle(1'b1, 4'b0101, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
`ifdef GRAY_SEQ_CHECK_EN
        check("sat_err_cnt", err_cnt, 8'hFF);
        check("sat_seq_err", seq_err, 1);
`else
        check("sat_err_cnt_off", err_cnt, 0);
        check("sat_seq_err_off", seq_err, 0);
`endif

        // Reset with two words buffered discards them.
        cycle(1'b1, 4'b0011, 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        check("full_gry_ready", gry_ready, 0);
        do_reset();
        repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
        check("post_rst_bin_valid", bin_valid, 0);
        check("post_rst_word_cnt", word_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
